// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the burst round-robin UART transmit arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2
    } state_e;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned BCNT_W       = 8;
    localparam int unsigned DEF_LOCK_MAX = 16;
    localparam int unsigned DEF_BUSY_TO  = 7;

    // Next requester index after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic            o_valid,
    output logic [IDW-1:0]  o_index,
    output logic [NREQ-1:0] o_onehot
);

    localparam int unsigned SEL_W = $clog2(NREQ);

    // Scan from the farthest candidate down so the nearest one is assigned last and wins.
    always_comb begin
        int unsigned w_cand;
        o_valid = 1'b0;
        o_index = '0;
        w_cand  = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_cand = (32'(i_ptr) + 32'(k)) % NREQ;
            if (i_req[SEL_W'(w_cand)]) begin
                o_valid = 1'b1;
                o_index = IDW'(w_cand);
            end
        end
        o_onehot = o_valid ? (NREQ'(1) << o_index) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte-stream requesters, round-robin per burst.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned LOCK_MAX = DEF_LOCK_MAX,
    parameter int unsigned BUSY_TO  = DEF_BUSY_TO
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NREQ-1:0]        req,
    input  logic [DATA_W*NREQ-1:0] din,
    input  logic [NREQ-1:0]        last,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        grant,
    output logic [IDW-1:0]         owner,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   err
);

    localparam int unsigned SEL_W   = $clog2(NREQ);
    localparam int unsigned TO_W    = $clog2(BUSY_TO + 1);
    localparam bit          LOCK_EN = (LOCK_MAX != 0);

    state_e              r_state, w_next;
    logic [IDW-1:0]      r_ptr;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [TO_W-1:0]     r_tcnt;
    logic                r_last_q;

    logic                w_pick_valid;
    logic [IDW-1:0]      w_pick_idx;
    logic [NREQ-1:0]     w_pick_onehot;
    logic                w_timeout_hit, w_lock_hit, w_end;
    logic                w_cap, w_new_burst, w_rel, w_timeout;
    logic [IDW-1:0]      w_cap_idx;
    logic [NREQ-1:0]     w_cap_onehot;

    uart_tx_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_valid  (w_pick_valid),
        .o_index  (w_pick_idx),
        .o_onehot (w_pick_onehot)
    );

    assign w_timeout_hit = (r_tcnt == TO_W'(BUSY_TO - 1));
    assign w_lock_hit    = LOCK_EN && (r_bcnt == BCNT_W'(LOCK_MAX));
    assign w_end         = r_last_q | ~req[SEL_W'(owner)] | w_lock_hit;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (!tx_busy && w_pick_valid) w_next = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (tx_busy)            w_next = ST_WAIT_LO;
                else if (w_timeout_hit) w_next = ST_IDLE;
            end
            ST_WAIT_LO: if (!tx_busy)   w_next = w_end ? ST_IDLE : ST_WAIT_HI;
            default:                    w_next = ST_IDLE;
        endcase
    end

    // Per-state datapath controls: capture a byte, release the burst, or flag a dead UART.
    always_comb begin
        w_cap        = 1'b0;
        w_new_burst  = 1'b0;
        w_rel        = 1'b0;
        w_timeout    = 1'b0;
        w_cap_idx    = owner;
        w_cap_onehot = NREQ'(1) << owner;
        case (r_state)
            ST_IDLE: begin
                if (!tx_busy && w_pick_valid) begin
                    w_cap        = 1'b1;
                    w_new_burst  = 1'b1;
                    w_cap_idx    = w_pick_idx;
                    w_cap_onehot = w_pick_onehot;
                end
            end
            ST_WAIT_HI: begin
                if (!tx_busy && w_timeout_hit) begin
                    w_timeout = 1'b1;
                    w_rel     = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (w_end) w_rel = 1'b1;
                    else       w_cap = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ack      <= '0;
            grant    <= '0;
            owner    <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            err      <= 1'b0;
            r_ptr    <= '0;
            r_bcnt   <= '0;
            r_tcnt   <= '0;
            r_last_q <= 1'b0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            if (w_cap) begin
                owner    <= w_cap_idx;
                grant    <= w_cap_onehot;
                tx_data  <= din[{w_cap_idx, 3'b000} +: DATA_W];
                tx_start <= 1'b1;
                ack      <= w_cap_onehot;
                r_last_q <= last[SEL_W'(w_cap_idx)];
                r_bcnt   <= w_new_burst ? BCNT_W'(1) : r_bcnt + 1'b1;
            end
            if (w_rel) begin
                grant <= '0;
                r_ptr <= IDW'(wrap_inc(32'(owner), NREQ));
            end
            if (w_timeout) err <= 1'b1;
            if (w_cap)
                r_tcnt <= '0;
            else if (r_state == ST_WAIT_HI && !tx_busy && !w_timeout_hit)
                r_tcnt <= r_tcnt + 1'b1;
        end
    end

endmodule
